// File: rtl/stream_record_extractor.sv
// Record extractor: packs input beats into a left-aligned byte buffer and emits
// one whole record (variable field, delimiter, fixed field) per output handshake.
module stream_record_extractor #(
    parameter int         DATA_BUS_WIDTH_BYTES     = 8,
    parameter int         MAX_VARIABLEFIELD_LENGTH = 16,
    parameter int         FIXEDFIELD_LENGTH_BYTES  = 17,
    parameter logic [7:0] VARIABLEFIELD_DELIMITER  = 8'h2c,
    parameter int         MAX_REC_BYTES            = MAX_VARIABLEFIELD_LENGTH + FIXEDFIELD_LENGTH_BYTES + 1,
    parameter int         BUF_BYTES                = MAX_REC_BYTES + DATA_BUS_WIDTH_BYTES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_BUS_WIDTH_BYTES*8-1:0]   s_data,
    input  logic                                s_valid,
    input  logic                                s_last,
    output logic                                s_ready,
    output logic [MAX_REC_BYTES*8-1:0]          rec_data,
    output logic [$clog2(MAX_REC_BYTES+1)-1:0]  rec_len,
    output logic                                rec_trunc,
    output logic                                rec_valid,
    input  logic                                rec_ready,
    output logic [15:0]                         drop_count
);
    localparam int CW = $clog2(BUF_BYTES + 1);
    localparam int LW = $clog2(MAX_REC_BYTES + 1);
    localparam int NB = $clog2(DATA_BUS_WIDTH_BYTES);
    localparam logic [CW-1:0] N_C    = CW'(DATA_BUS_WIDTH_BYTES);
    localparam logic [CW-1:0] ROOM_C = CW'(BUF_BYTES - DATA_BUS_WIDTH_BYTES);
    localparam logic [CW-1:0] MAXV_C = CW'(MAX_VARIABLEFIELD_LENGTH);
    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [BUF_BYTES*8-1:0]     bufReg, bufNext, shiftFlat;
    logic [CW-1:0]              cntReg, cntNext, dropSkipReg, dropSkipNext;
    logic [1:0]                 stateReg, stateNext;
    logic                       pendLastReg, pendLastNext;
    logic [MAX_REC_BYTES*8-1:0] recDataReg;
    logic [LW-1:0]              recLenReg, loadLen;
    logic                       recTruncReg, recValidReg, loadTrunc, loadRec, clearValid;
    logic [15:0]                dropCountReg;
    logic                       dropInc, sReady, accept;
    logic [CW-1:0]              shamt, wrBase, dIdx;
    logic                       found, complete, overlong, fullTail;
    logic [CW:0]                recEnd;

    // Lowest delimiter among the valid bytes
    always_comb begin
        found = 1'b0;
        dIdx  = '0;
        for (int i = BUF_BYTES - 1; i >= 0; i--) begin
            if ((CW'(i) < cntReg) && (bufReg[i*8 +: 8] == VARIABLEFIELD_DELIMITER)) begin
                found = 1'b1;
                dIdx  = CW'(i);
            end
        end
    end

    assign recEnd   = {1'b0, dIdx} + (CW+1)'(FIXEDFIELD_LENGTH_BYTES + 1);
    assign fullTail = found && ({1'b0, cntReg} >= recEnd);
    assign complete = fullTail && (dIdx <= MAXV_C);
    assign overlong = !(found && (dIdx <= MAXV_C)) && (cntReg > MAXV_C);

    always_comb begin
        stateNext    = stateReg;
        pendLastNext = pendLastReg;
        dropSkipNext = dropSkipReg;
        shamt        = '0;
        sReady       = 1'b0;
        loadRec      = 1'b0;
        loadLen      = '0;
        loadTrunc    = 1'b0;
        clearValid   = 1'b0;
        dropInc      = 1'b0;
        case (stateReg)
            FILL: begin
                sReady = (cntReg <= ROOM_C) && !complete;
                if (complete) begin
                    stateNext = EMIT;
                    loadRec   = 1'b1;
                    loadLen   = LW'(recEnd);
                end else if (overlong) begin
                    stateNext    = DROP;
                    dropInc      = 1'b1;
                    dropSkipNext = '0;
                end else if (pendLastReg && (cntReg != '0)) begin
                    stateNext = EMIT;
                    loadRec   = 1'b1;
                    loadLen   = LW'(cntReg);
                    loadTrunc = 1'b1;
                end else if (pendLastReg) begin
                    pendLastNext = 1'b0;
                end
            end
            EMIT: begin
                if (rec_ready) begin
                    clearValid = 1'b1;
                    shamt      = CW'(recLenReg);
                    stateNext  = FILL;
                    if (recTruncReg) pendLastNext = 1'b0;
                end
            end
            DROP: begin
                sReady = (cntReg <= ROOM_C);
                // dropSkipReg counts fixed-field bytes of a dropped record that
                // no longer fit in the buffer; they are consumed as they arrive.
                if (dropSkipReg != '0) begin
                    if (cntReg >= dropSkipReg) begin
                        shamt        = dropSkipReg;
                        dropSkipNext = '0;
                        stateNext    = FILL;
                    end else if (pendLastReg) begin
                        shamt        = cntReg;
                        dropSkipNext = '0;
                        pendLastNext = 1'b0;
                        stateNext    = FILL;
                    end else begin
                        shamt        = cntReg;
                        dropSkipNext = dropSkipReg - cntReg;
                    end
                end else if (fullTail) begin
                    shamt     = CW'(recEnd);
                    stateNext = FILL;
                end else if (pendLastReg) begin
                    shamt        = cntReg;
                    pendLastNext = 1'b0;
                    stateNext    = FILL;
                end else if (!found) begin
                    shamt = cntReg;
                end else if (cntReg > ROOM_C) begin
                    shamt        = cntReg;
                    dropSkipNext = CW'(recEnd - {1'b0, cntReg});
                end
            end
            default: stateNext = FILL;
        endcase
        accept = s_valid && sReady;
        if (accept && s_last) pendLastNext = 1'b1;
        cntNext = cntReg - shamt + (accept ? N_C : '0);
    end

    // Shift out consumed bytes, then land the accepted beat right after the survivors
    assign shiftFlat = bufReg >> {shamt, 3'b000};
    assign wrBase    = cntReg - shamt;

    for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : genByte
        logic [CW-1:0] off;
        assign off = CW'(gi) - wrBase;
        assign bufNext[gi*8 +: 8] = (accept && (off < N_C)) ? s_data[{off[NB-1:0], 3'b000} +: 8]
                                                           : shiftFlat[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg     <= FILL;
            cntReg       <= '0;
            bufReg       <= '0;
            pendLastReg  <= 1'b0;
            dropSkipReg  <= '0;
            recDataReg   <= '0;
            recLenReg    <= '0;
            recTruncReg  <= 1'b0;
            recValidReg  <= 1'b0;
            dropCountReg <= '0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            bufReg      <= bufNext;
            pendLastReg <= pendLastNext;
            dropSkipReg <= dropSkipNext;
            if (loadRec) begin
                recDataReg  <= bufReg[MAX_REC_BYTES*8-1:0];
                recLenReg   <= loadLen;
                recTruncReg <= loadTrunc;
                recValidReg <= 1'b1;
            end else if (clearValid) begin
                recValidReg <= 1'b0;
            end
            if (dropInc && (dropCountReg != 16'hFFFF)) dropCountReg <= dropCountReg + 16'd1;
        end
    end

    assign s_ready    = sReady;
    assign rec_data   = recDataReg;
    assign rec_len    = recLenReg;
    assign rec_trunc  = recTruncReg;
    assign rec_valid  = recValidReg;
    assign drop_count = dropCountReg;
endmodule

// File: tb/tb_stream_record_extractor.sv
// Directed bench for stream_record_extractor: single, paired, backpressured,
// overlong, maximum-length and frame-tail records plus reset during emission.
module tb_stream_record_extractor;
    localparam int N      = 8;
    localparam int MAXREC = 34;
    localparam int LW     = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic [N*8-1:0]      s_data;
    logic                s_valid, s_last, s_ready;
    logic [MAXREC*8-1:0] rec_data;
    logic [LW-1:0]       rec_len;
    logic                rec_trunc, rec_valid, rec_ready;
    logic [15:0]         drop_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]          sb [0:127];
    int                  sbLen;
    logic [MAXREC*8-1:0] qData [$];
    int                  qLen [$];
    logic                qTrunc [$];

    stream_record_extractor dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .rec_data(rec_data), .rec_len(rec_len), .rec_trunc(rec_trunc),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && rec_valid && rec_ready) begin
            qData.push_back(rec_data);
            qLen.push_back(int'(rec_len));
            qTrunc.push_back(rec_trunc);
            $display("record: len=%0d trunc=%0d head=%h", rec_len, rec_trunc, rec_data[31:0]);
        end
    end

    function automatic logic [MAXREC*8-1:0] expData(input int start, input int len);
        logic [MAXREC*8-1:0] v = '0;
        for (int i = 0; i < len; i++) v[i*8 +: 8] = sb[start+i];
        return v;
    endfunction

    function automatic logic [MAXREC*8-1:0] lenMask(input int len);
        logic [MAXREC*8-1:0] m = '0;
        for (int i = 0; i < len; i++) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic addByte(input logic [7:0] b);
        sb[sbLen] = b;
        sbLen++;
    endtask

    task automatic addGood();
        addByte(8'h41); addByte(8'h42); addByte(8'h43); addByte(8'h2C);
        for (int i = 0; i < 17; i++) addByte(8'(8'h41 + i));
    endtask

    task automatic addOverlongThenGood();
        for (int i = 0; i < 20; i++) addByte(8'(8'h41 + i));
        addByte(8'h2C);
        for (int i = 0; i < 17; i++) addByte(8'(8'h61 + i));
        addGood();
        for (int i = 0; i < 5; i++) addByte(8'h5A);
    endtask

    task automatic clearAll();
        sbLen = 0;
        qData.delete(); qLen.delete(); qTrunc.delete();
    endtask

    task automatic doReset();
        reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; rec_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clearAll();
    endtask

    task automatic sendBeat(input logic [N*8-1:0] data, input logic last);
        int w = 0;
        s_data = data; s_valid = 1'b1; s_last = last;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, w);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic sendStream(input logic lastFlag);
        logic [N*8-1:0] d;
        for (int b = 0; b < sbLen / N; b++) begin
            for (int j = 0; j < N; j++) d[j*8 +: 8] = sb[b*N + j];
            sendBeat(d, lastFlag && (b == sbLen / N - 1));
        end
    endtask

    task automatic waitRecords(input int n);
        for (int w = 0; w < 300 && qLen.size() < n; w++) @(negedge clk);
    endtask

    task automatic waitValid();
        for (int w = 0; w < 100 && !rec_valid; w++) @(negedge clk);
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_rec_valid: got %0b, required 0", rec_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b, required 1", s_ready); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d, required 0", drop_count); end
        checks++; if (rec_len !== '0) begin errors++; $display("FAIL reset_rec_len: got %0d, required 0", rec_len); end
        checks++; if (rec_trunc !== 1'b0) begin errors++; $display("FAIL reset_rec_trunc: got %0b, required 0", rec_trunc); end
        checks++; if (rec_data !== '0) begin errors++; $display("FAIL reset_rec_data: got %h, required 0", rec_data); end
    endtask

    task automatic test_single_record();
        logic [N*8-1:0] d;
        doReset();
        addGood(); addByte(8'h58); addByte(8'h59); addByte(8'h5A);
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < N; j++) d[j*8 +: 8] = sb[b*N + j];
            sendBeat(d, 1'b0);
        end
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b, required 0", rec_valid); end
        @(negedge clk);
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL single_latency: rec_valid=%0b, required 1", rec_valid); end
        checks++; if (rec_len !== 6'd21) begin errors++; $display("FAIL single_len: got %0d, required 21", rec_len); end
        checks++; if (rec_data[31:0] !== 32'h2C434241) begin errors++; $display("FAIL single_head: got %h, required 2c434241", rec_data[31:0]); end
        checks++; if ((rec_data & lenMask(21)) !== expData(0, 21)) begin errors++; $display("FAIL single_data: got %h, required %h", rec_data & lenMask(21), expData(0, 21)); end
        checks++; if (rec_trunc !== 1'b0) begin errors++; $display("FAIL single_trunc: got %0b, required 0", rec_trunc); end
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL single_count: got %0d records, required 1", qLen.size()); end
    endtask

    task automatic test_two_records();
        doReset();
        addGood();
        addByte(8'h61); addByte(8'h2C);
        for (int i = 0; i < 17; i++) addByte(8'(8'h70 + i));
        rec_ready = 1'b1;
        sendStream(1'b0);
        waitRecords(2);
        repeat (4) @(negedge clk);
        rec_ready = 1'b0;
        checks++; if (qLen.size() != 2) begin errors++; $display("FAIL two_count: got %0d records, required 2", qLen.size()); end
        if (qLen.size() >= 2) begin
            checks++; if (qLen[0] != 21) begin errors++; $display("FAIL two_len0: got %0d, required 21", qLen[0]); end
            checks++; if (qLen[1] != 19) begin errors++; $display("FAIL two_len1: got %0d, required 19", qLen[1]); end
            checks++; if ((qData[0] & lenMask(21)) !== expData(0, 21)) begin errors++; $display("FAIL two_data0: got %h, required %h", qData[0] & lenMask(21), expData(0, 21)); end
            checks++; if ((qData[1] & lenMask(19)) !== expData(21, 19)) begin errors++; $display("FAIL two_data1: got %h, required %h", qData[1] & lenMask(19), expData(21, 19)); end
            checks++; if (qData[1][7:0] !== 8'h61) begin errors++; $display("FAIL two_byte0: got %h, required 61", qData[1][7:0]); end
        end
    endtask

    task automatic test_backpressure();
        doReset();
        addGood(); addByte(8'h58); addByte(8'h59); addByte(8'h5A);
        sendStream(1'b0);
        waitValid();
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: rec_valid=%0b, required 1", rec_valid); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rec_valid !== 1'b1 || s_ready !== 1'b0 || (rec_data & lenMask(21)) !== expData(0, 21)) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%0b s_ready=%0b data=%h, required valid=1 s_ready=0 data=%h",
                         c, rec_valid, s_ready, rec_data & lenMask(21), expData(0, 21));
            end
        end
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b, required 0", rec_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b, required 1", s_ready); end
        repeat (3) @(negedge clk);
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL bp_count: got %0d records, required 1", qLen.size()); end
    endtask

    task automatic test_overlong();
        doReset();
        addOverlongThenGood();
        rec_ready = 1'b1;
        sendStream(1'b0);
        waitRecords(1);
        repeat (10) @(negedge clk);
        rec_ready = 1'b0;
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovl_drop_count: got %0d, required 1", drop_count); end
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL ovl_count: got %0d records, required 1", qLen.size()); end
        if (qLen.size() >= 1) begin
            checks++; if (qLen[0] != 21) begin errors++; $display("FAIL ovl_len: got %0d, required 21", qLen[0]); end
            checks++; if ((qData[0] & lenMask(21)) !== expData(38, 21)) begin errors++; $display("FAIL ovl_data: got %h, required %h", qData[0] & lenMask(21), expData(38, 21)); end
        end
    endtask

    task automatic test_max_record();
        doReset();
        for (int i = 0; i < 16; i++) addByte(8'(8'h30 + i));
        addByte(8'h2C);
        for (int i = 0; i < 17; i++) addByte(8'(8'h41 + i));
        for (int i = 0; i < 6; i++) addByte(8'h5A);
        rec_ready = 1'b1;
        sendStream(1'b0);
        waitRecords(1);
        rec_ready = 1'b0;
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL max_count: got %0d records, required 1", qLen.size()); end
        if (qLen.size() >= 1) begin
            checks++; if (qLen[0] != 34) begin errors++; $display("FAIL max_len: got %0d, required 34", qLen[0]); end
            checks++; if (qData[0] !== expData(0, 34)) begin errors++; $display("FAIL max_data: got %h, required %h", qData[0], expData(0, 34)); end
            checks++; if (qTrunc[0] !== 1'b0) begin errors++; $display("FAIL max_trunc: got %0b, required 0", qTrunc[0]); end
        end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL max_drop_count: got %0d, required 0", drop_count); end
    endtask

    task automatic test_frame_tail();
        doReset();
        addByte(8'h41); addByte(8'h42); addByte(8'h2C);
        for (int i = 0; i < 5; i++) addByte(8'(8'h31 + i));
        addByte(8'h36); addByte(8'h37); addByte(8'h38); addByte(8'h39);
        addByte(8'h30); addByte(8'h31); addByte(8'h32); addByte(8'h33);
        rec_ready = 1'b1;
        sendStream(1'b1);
        waitRecords(1);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL tail_s_ready: got %0b, required 1", s_ready); end
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL tail_count: got %0d records, required 1", qLen.size()); end
        if (qLen.size() >= 1) begin
            checks++; if (qLen[0] != 16) begin errors++; $display("FAIL tail_len: got %0d, required 16", qLen[0]); end
            checks++; if (qTrunc[0] !== 1'b1) begin errors++; $display("FAIL tail_trunc: got %0b, required 1", qTrunc[0]); end
            checks++; if ((qData[0] & lenMask(16)) !== expData(0, 16)) begin errors++; $display("FAIL tail_data: got %h, required %h", qData[0] & lenMask(16), expData(0, 16)); end
        end
        clearAll();
        addGood(); addByte(8'h58); addByte(8'h59); addByte(8'h5A);
        sendStream(1'b0);
        waitRecords(1);
        rec_ready = 1'b0;
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL tail_next_count: got %0d records, required 1", qLen.size()); end
        if (qLen.size() >= 1) begin
            checks++; if (qLen[0] != 21 || qTrunc[0] !== 1'b0) begin errors++; $display("FAIL tail_next_len: got len=%0d trunc=%0b, required len=21 trunc=0", qLen[0], qTrunc[0]); end
            checks++; if ((qData[0] & lenMask(21)) !== expData(0, 21)) begin errors++; $display("FAIL tail_next_data: got %h, required %h", qData[0] & lenMask(21), expData(0, 21)); end
        end
    endtask

    task automatic test_reset_mid_emit();
        doReset();
        addOverlongThenGood();
        sendStream(1'b0);
        waitValid();
        checks++; if (rec_valid !== 1'b1 || drop_count !== 16'd1) begin errors++; $display("FAIL rst_pre: valid=%0b drop=%0d, required valid=1 drop=1", rec_valid, drop_count); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL rst_rec_valid: got %0b, required 0", rec_valid); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop_count: got %0d, required 0", drop_count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %0b, required 1", s_ready); end
        checks++; if (rec_len !== '0 || rec_trunc !== 1'b0) begin errors++; $display("FAIL rst_len_trunc: got len=%0d trunc=%0b, required 0 0", rec_len, rec_trunc); end
        clearAll();
        addGood(); addByte(8'h58); addByte(8'h59); addByte(8'h5A);
        rec_ready = 1'b1;
        sendStream(1'b0);
        waitRecords(1);
        rec_ready = 1'b0;
        checks++; if (qLen.size() != 1) begin errors++; $display("FAIL rst_fresh_count: got %0d records, required 1", qLen.size()); end
        if (qLen.size() >= 1) begin
            checks++; if (qLen[0] != 21) begin errors++; $display("FAIL rst_fresh_len: got %0d, required 21", qLen[0]); end
            checks++; if ((qData[0] & lenMask(21)) !== expData(0, 21)) begin errors++; $display("FAIL rst_fresh_data: got %h, required %h", qData[0] & lenMask(21), expData(0, 21)); end
        end
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; rec_ready = 1'b0; sbLen = 0;
        test_reset();
        test_single_record();
        test_two_records();
        test_backpressure();
        test_overlong();
        test_max_record();
        test_frame_tail();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
